// File: rtl/my_112l_pkg.sv
`default_nettype none
// ============================================================================
// Package  : my_112l_pkg
// Purpose  : Shared fetch/decode types: IF/ID bundle and the bubble opcode.
// Revision : 1.0  initial release
// ============================================================================
package my_112l_pkg;

    localparam int IF_ID_XLEN = 32;

    // addi x0,x0,0 -- architectural no-op presented when no instruction is held
    localparam logic [IF_ID_XLEN-1:0] BUBBLE_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [IF_ID_XLEN-1:0] instruction;
        logic [IF_ID_XLEN-1:0] pc;
        logic [IF_ID_XLEN-1:0] pcplus4;
    } IF_ID;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO with flush; head is visible combinationally.
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + (c_ptr_w+1)'(1);
            end else if (!push && pop) begin
                r_count <= r_count - (c_ptr_w+1)'(1);
            end
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction fetch: owns fetch PC, issues in-order imem requests,
//            buffers responses with their PC and feeds the IF/ID register.
// Revision : 1.0  initial release
// ============================================================================
module if_fetch_unit
    import my_112l_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output IF_ID            out
);

    localparam int                 c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w+1:0] c_depth = (c_cnt_w+2)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]    c_step  = XLEN'(4);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [c_cnt_w-1:0] r_inflight;
    logic [c_cnt_w-1:0] r_discard;

    logic [c_cnt_w-1:0] w_tag_count;
    logic [c_cnt_w-1:0] w_insn_count;
    logic [XLEN-1:0]    w_tag_head;
    logic [2*XLEN-1:0]  w_insn_head;
    logic [c_cnt_w+1:0] w_occupancy;
    logic               w_issue;
    logic               w_ack_take;
    logic               w_valid;
    logic               w_pop;

    // Every slot is reserved at issue time, so buffered data can never overflow.
    assign w_occupancy = (c_cnt_w+2)'(r_inflight) + (c_cnt_w+2)'(r_discard)
                       + (c_cnt_w+2)'(w_insn_count);
    assign w_issue     = !reset && !redirect && (w_occupancy < c_depth);
    assign w_ack_take  = imem_ack && !reset && !redirect && (r_discard == '0);
    assign w_valid     = !reset && (w_insn_count != '0);
    assign w_pop       = w_valid && !stall && !redirect;

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (w_issue),
        .push_data (r_fetch_pc),
        .pop       (w_ack_take),
        .flush     (redirect),
        .count     (w_tag_count),
        .head      (w_tag_head)
    );

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_insn_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (w_ack_take),
        .push_data ({w_tag_head, imem_rdata}),
        .pop       (w_pop),
        .flush     (redirect),
        .count     (w_insn_count),
        .head      (w_insn_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else if (redirect) begin
            // Everything still outstanding becomes a discard; a same-cycle ack retires one.
            r_fetch_pc <= redirect_pc;
            r_inflight <= '0;
            r_discard  <= r_discard + r_inflight - c_cnt_w'(imem_ack);
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + c_step;
            end
            if (imem_ack && (r_discard != '0)) begin
                r_discard <= r_discard - c_cnt_w'(1);
            end
            r_inflight <= r_inflight + c_cnt_w'(w_issue) - c_cnt_w'(w_ack_take);
        end
    end

    assign imem_req  = w_issue;
    assign imem_addr = reset ? RESET_PC : r_fetch_pc;
    assign out_valid = w_valid;

    always_comb begin
        out.instruction = BUBBLE_INSN;
        out.pc          = '0;
        out.pcplus4     = '0;
        if (w_valid) begin
            out.instruction = w_insn_head[XLEN-1:0];
            out.pc          = w_insn_head[2*XLEN-1:XLEN];
            out.pcplus4     = w_insn_head[2*XLEN-1:XLEN] + c_step;
        end
    end

    a_ack_has_owner: assert property (@(posedge clk) disable iff (reset)
        imem_ack |-> ((r_inflight != '0) || (r_discard != '0)));

    a_tags_track_inflight: assert property (@(posedge clk) disable iff (reset)
        w_tag_count == r_inflight);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// Bench for if_fetch_unit: directed scenarios plus random traffic, checked
// against a queue-level model of outstanding requests and buffered words.
module tb_if_fetch_unit;
    import my_112l_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;
    localparam int          DEPTH    = 4;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_ack    = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        out_valid;
    IF_ID        out;

    logic        reset2 = 1'b1;
    logic        ack2   = 1'b0;
    logic [31:0] rdata2 = '0;
    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    IF_ID        out2;

    always #5 clk = ~clk;

    if_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk (clk), .reset (reset), .stall (stall), .redirect (redirect),
        .redirect_pc (redirect_pc), .imem_req (imem_req), .imem_addr (imem_addr),
        .imem_ack (imem_ack), .imem_rdata (imem_rdata), .out_valid (out_valid), .out (out)
    );

    if_fetch_unit #(.XLEN(32), .RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
        .clk (clk), .reset (reset2), .stall (1'b0), .redirect (1'b0),
        .redirect_pc (32'h0), .imem_req (req2), .imem_addr (addr2),
        .imem_ack (ack2), .imem_rdata (rdata2), .out_valid (valid2), .out (out2)
    );

    typedef struct { logic [31:0] pc; bit drop; }            req_t;
    typedef struct { logic [31:0] pc; logic [31:0] insn; }   buf_t;
    typedef struct { logic [31:0] addr; int due; }           mem_t;

    req_t        m_req_q[$];
    buf_t        m_buf_q[$];
    mem_t        mem_q[$];
    logic [31:0] m_pc = RESET_PC;
    int          cyc = 0;
    int          last_due = 0;
    int          n_compared = 0;
    int          n_mismatched = 0;
    bit          wrap_done = 1'b0;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of the main DUT: drive inputs, compare outputs, advance memory and model.
    task automatic step(input bit rst_i, input bit stall_i, input bit redir_i,
                        input logic [31:0] rpc_i, input int lat);
        bit          ack_now;
        bit          exp_req;
        bit          exp_valid;
        bit          new_push;
        logic [31:0] exp_addr;
        logic [95:0] exp_out;
        req_t        r;
        buf_t        b;
        mem_t        m;
        @(negedge clk);
        new_push    = 1'b0;
        ack_now     = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        reset       = rst_i;
        stall       = stall_i;
        redirect    = redir_i;
        redirect_pc = rpc_i;
        imem_ack    = ack_now;
        imem_rdata  = $urandom;
        if (ack_now) begin
            m = mem_q.pop_front();
            imem_rdata = hash(m.addr);
        end
        #1;
        exp_req   = !rst_i && !redir_i && ((m_req_q.size() + m_buf_q.size()) < DEPTH);
        exp_addr  = rst_i ? RESET_PC : m_pc;
        exp_valid = !rst_i && (m_buf_q.size() > 0);
        exp_out   = {BUBBLE_INSN, 64'h0};
        if (exp_valid) exp_out = {m_buf_q[0].insn, m_buf_q[0].pc, m_buf_q[0].pc + 32'd4};
        chk("imem_req", 96'(imem_req), 96'(exp_req));
        chk("imem_addr", 96'(imem_addr), 96'(exp_addr));
        chk("out_valid", 96'(out_valid), 96'(exp_valid));
        chk("out", out, exp_out);

        if (imem_req) begin
            m.addr = imem_addr;
            m.due  = cyc + lat;
            if (m.due <= last_due) m.due = last_due + 1;
            last_due = m.due;
            mem_q.push_back(m);
        end

        if (rst_i) begin
            m_req_q.delete();
            m_buf_q.delete();
            m_pc = RESET_PC;
        end else begin
            if (ack_now && (m_req_q.size() > 0)) begin
                r = m_req_q.pop_front();
                if (!r.drop && !redir_i) begin
                    b.pc     = r.pc;
                    b.insn   = imem_rdata;
                    new_push = 1'b1;
                end
            end
            if (redir_i) begin
                for (int i = 0; i < m_req_q.size(); i++) m_req_q[i].drop = 1'b1;
                m_buf_q.delete();
                m_pc = rpc_i;
            end else begin
                if ((m_buf_q.size() > 0) && !stall_i) m_buf_q.delete(0);
                if (new_push) m_buf_q.push_back(b);
                if (exp_req) begin
                    r.pc   = m_pc;
                    r.drop = 1'b0;
                    m_req_q.push_back(r);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    // Second instance: reset PC near the top of the address space, latency-1 memory.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        logic [31:0] first3 [3];
        int          idx;
        bit          saw_top;
        pend = 1'b0; pend_addr = '0; idx = 0; saw_top = 1'b0;
        for (int i = 0; i < 3; i++) first3[i] = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        chk("wrap_reset_addr", 96'(addr2), 96'(WRAP_PC));
        chk("wrap_reset_req", 96'(req2), 96'(0));
        @(negedge clk);
        reset2 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            ack2   = pend;
            rdata2 = hash(pend_addr);
            #1;
            if (req2 && idx < 3) begin
                first3[idx] = addr2;
                idx++;
            end
            pend = req2;
            pend_addr = addr2;
            if (valid2 && (out2.pc == 32'hFFFF_FFFC)) begin
                saw_top = 1'b1;
                chk("wrap_pcplus4", 96'(out2.pcplus4), 96'(0));
                chk("wrap_insn", 96'(out2.instruction), 96'(hash(32'hFFFF_FFFC)));
            end
            @(negedge clk);
        end
        ack2   = 1'b0;
        reset2 = 1'b1;
        chk("wrap_req0", 96'(first3[0]), 96'(32'hFFFF_FFF8));
        chk("wrap_req1", 96'(first3[1]), 96'(32'hFFFF_FFFC));
        chk("wrap_req2", 96'(first3[2]), 96'(32'h0000_0000));
        chk("wrap_saw_top", 96'(saw_top), 96'(1));
        wrap_done = 1'b1;
    end

    initial begin
        bit hold;
        bit r_rst;
        hold = 1'b0;

        repeat (3)  step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        repeat (12) step(1'b0, 1'b0, 1'b0, 32'h0, 1);

        repeat (6)  step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        repeat (12) step(1'b0, 1'b0, 1'b0, 32'h0, 1);

        for (int i = 0; i < 50 && m_req_q.size() != 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 3);
        chk("p3_two_inflight", 96'(m_req_q.size()), 96'(2));
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 3);
        repeat (12) step(1'b0, 1'b0, 1'b0, 32'h0, 1);

        for (int i = 0; i < 50 && !((mem_q.size() > 0) && (mem_q[0].due <= cyc) && (m_buf_q.size() > 0)); i++)
            step(1'b0, 1'b0, 1'b0, 32'h0, 2);
        chk("p4_ack_ready", 96'((mem_q.size() > 0) && (mem_q[0].due <= cyc)), 96'(1));
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200, 2);
        step(1'b0, 1'b1, 1'b0, 32'h0, 2);
        repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0, 1);

        for (int i = 0; i < 50 && m_req_q.size() != 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 3);
        chk("p6_three_inflight", 96'(m_req_q.size()), 96'(3));
        step(1'b1, 1'b0, 1'b0, 32'h0, 3);
        for (int i = 0; i < 20 && mem_q.size() > 0; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 3);
        chk("p6_acks_drained", 96'(mem_q.size()), 96'(0));
        repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0, 1);

        for (int i = 0; i < 3000; i++) begin
            r_rst = hold || ($urandom_range(0, 199) == 0);
            step(r_rst, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 6),
                 ($urandom & 32'hFFFF_FFFC), int'($urandom_range(1, 4)));
            hold = r_rst && (mem_q.size() > 0);
        end

        for (int i = 0; i < 100 && !wrap_done; i++) @(negedge clk);
        chk("wrap_done", 96'(wrap_done), 96'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
